// File: rtl/data_island_scheduler_pkg.sv
// Shared definitions for the HDMI data-island packet path.
// Provides the packet-source enumeration used to index the per-source
// header/subpacket buses and the packet field widths.
package hdmi_packet_pkg;

  // Packet source identifiers; values 1..5 index src_header_i / src_sub_i
  typedef enum logic [2:0] {
    PKT_NULL       = 3'd0,
    PKT_ACR        = 3'd1,
    PKT_AUDIO      = 3'd2,
    PKT_AVI        = 3'd3,
    PKT_AUDIO_INFO = 3'd4,
    PKT_SPD        = 3'd5
  } pkt_src_t;

  localparam int HEADER_W = 24;
  localparam int SUB_W    = 56;
  localparam int NUM_SUB  = 4;
  localparam int NUM_SRC  = 5;

endpackage

// File: rtl/data_island_scheduler_tracker.sv
// infoframe_pending_tracker
// Holds one pending bit per InfoFrame type (AVI, audio InfoFrame, SPD).
// A frame start requests all three; a grant retires its own bit. When a
// frame start and a grant land on the same cycle the request wins, so a
// frame's InfoFrame is never lost and never queued twice.
// Ports:
//   clk_i            pixel clock
//   reset_i          synchronous, active-high
//   frame_start_i    1-cycle strobe, sets all pending bits
//   grant_avi_i      AVI InfoFrame granted this cycle
//   grant_ainfo_i    audio InfoFrame granted this cycle
//   grant_spd_i      SPD InfoFrame granted this cycle
//   avi_pending_o    AVI InfoFrame waiting
//   ainfo_pending_o  audio InfoFrame waiting
//   spd_pending_o    SPD InfoFrame waiting (always 0 when SPD_ENABLE=0)
//   any_pending_o    OR of the three pending bits
module infoframe_pending_tracker #(
  parameter bit SPD_ENABLE = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic frame_start_i,
  input  logic grant_avi_i,
  input  logic grant_ainfo_i,
  input  logic grant_spd_i,
  output logic avi_pending_o,
  output logic ainfo_pending_o,
  output logic spd_pending_o,
  output logic any_pending_o
);

  logic avi_q, avi_d;
  logic ainfo_q, ainfo_d;
  logic spd_q, spd_d;

  // Set-wins update: a new frame request overrides a same-cycle grant
  always_comb begin
    avi_d   = frame_start_i | (avi_q & ~grant_avi_i);
    ainfo_d = frame_start_i | (ainfo_q & ~grant_ainfo_i);
    spd_d   = SPD_ENABLE & (frame_start_i | (spd_q & ~grant_spd_i));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      avi_q   <= 1'b0;
      ainfo_q <= 1'b0;
      spd_q   <= 1'b0;
    end else begin
      avi_q   <= avi_d;
      ainfo_q <= ainfo_d;
      spd_q   <= spd_d;
    end
  end

  assign avi_pending_o   = avi_q;
  assign ainfo_pending_o = ainfo_q;
  assign spd_pending_o   = spd_q;
  assign any_pending_o   = avi_q | ainfo_q | spd_q;

endmodule

// File: rtl/data_island_scheduler.sv
// data_island_scheduler
// Picks the packet for each HDMI data-island slot from ACR, audio sample,
// AVI / audio / SPD InfoFrames or null, and muxes the chosen source's header
// and subpackets onto a registered output for the TERC4 packet assembler.
// The decision is taken on the packet_enable cycle and appears one cycle
// later; outputs hold until the next decision.
// Ports:
//   clk_pixel_i               pixel clock (sole clock)
//   reset_i                   synchronous, active-high
//   packet_enable_i           1-cycle strobe, a new packet slot starts
//   frame_start_i             1-cycle strobe at start of each video frame
//   clk_audio_counter_wrap_i  toggle from ACR generator, each edge = ACR due
//   audio_sample_ready_i      audio sample packet available (level)
//   src_header_i[5:1]         per-source headers, indexed by pkt_src_t
//   src_sub_i[5:1]            per-source 4x56 subpackets, indexed by pkt_src_t
//   audio_sample_pop_o        1-cycle strobe, audio packet consumed
//   header_o                  selected header (0 for null)
//   sub_o[3:0]                selected subpackets (0 for null)
//   packet_src_o              source of the current packet
module data_island_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int MAX_AUDIO_BURST = 3,
  parameter bit SPD_ENABLE      = 1'b1
) (
  input  logic                                   clk_pixel_i,
  input  logic                                   reset_i,
  input  logic                                   packet_enable_i,
  input  logic                                   frame_start_i,
  input  logic                                   clk_audio_counter_wrap_i,
  input  logic                                   audio_sample_ready_i,
  input  logic [NUM_SRC:1][HEADER_W-1:0]         src_header_i,
  input  logic [NUM_SRC:1][NUM_SUB-1:0][SUB_W-1:0] src_sub_i,
  output logic                                   audio_sample_pop_o,
  output logic [HEADER_W-1:0]                    header_o,
  output logic [NUM_SUB-1:0][SUB_W-1:0]          sub_o,
  output pkt_src_t                               packet_src_o
);

  localparam int BURST_W = $clog2(MAX_AUDIO_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_AUDIO_BURST);

  logic                          wrap_q;
  logic                          acr_pending_q, acr_pending_d;
  logic [BURST_W-1:0]            burst_q, burst_d;
  pkt_src_t                      packet_src_q, packet_src_d;
  logic [HEADER_W-1:0]           header_q, header_d;
  logic [NUM_SUB-1:0][SUB_W-1:0] sub_q, sub_d;
  logic                          pop_q, pop_d;

  logic acr_edge;
  logic grant_acr, grant_audio, grant_avi, grant_ainfo, grant_spd;
  logic avi_pending, ainfo_pending, spd_pending, any_pending;

  infoframe_pending_tracker #(
    .SPD_ENABLE(SPD_ENABLE)
  ) u_tracker (
    .clk_i           (clk_pixel_i),
    .reset_i         (reset_i),
    .frame_start_i   (frame_start_i),
    .grant_avi_i     (grant_avi),
    .grant_ainfo_i   (grant_ainfo),
    .grant_spd_i     (grant_spd),
    .avi_pending_o   (avi_pending),
    .ainfo_pending_o (ainfo_pending),
    .spd_pending_o   (spd_pending),
    .any_pending_o   (any_pending)
  );

  // Any edge of the toggle means one ACR packet is owed
  assign acr_edge = clk_audio_counter_wrap_i ^ wrap_q;

  // Priority arbitration; audio is throttled after a full burst only while
  // some InfoFrame is waiting. The final audio fallback can only be reached
  // if the InfoFrame branch is empty, which the throttle condition already
  // excludes, but it keeps the rule list complete.
  always_comb begin
    packet_src_d = PKT_NULL;
    if (acr_pending_q) begin
      packet_src_d = PKT_ACR;
    end else if (audio_sample_ready_i && ((burst_q < BURST_MAX) || !any_pending)) begin
      packet_src_d = PKT_AUDIO;
    end else if (avi_pending) begin
      packet_src_d = PKT_AVI;
    end else if (ainfo_pending) begin
      packet_src_d = PKT_AUDIO_INFO;
    end else if (spd_pending) begin
      packet_src_d = PKT_SPD;
    end else if (audio_sample_ready_i) begin
      packet_src_d = PKT_AUDIO;
    end
  end

  // Grants only exist on slot-start cycles
  always_comb begin
    grant_acr   = packet_enable_i && (packet_src_d == PKT_ACR);
    grant_audio = packet_enable_i && (packet_src_d == PKT_AUDIO);
    grant_avi   = packet_enable_i && (packet_src_d == PKT_AVI);
    grant_ainfo = packet_enable_i && (packet_src_d == PKT_AUDIO_INFO);
    grant_spd   = packet_enable_i && (packet_src_d == PKT_SPD);
  end

  // Source mux; null sends an all-zero packet
  always_comb begin
    header_d = '0;
    sub_d    = '0;
    case (packet_src_d)
      PKT_ACR: begin
        header_d = src_header_i[1];
        sub_d    = src_sub_i[1];
      end
      PKT_AUDIO: begin
        header_d = src_header_i[2];
        sub_d    = src_sub_i[2];
      end
      PKT_AVI: begin
        header_d = src_header_i[3];
        sub_d    = src_sub_i[3];
      end
      PKT_AUDIO_INFO: begin
        header_d = src_header_i[4];
        sub_d    = src_sub_i[4];
      end
      PKT_SPD: begin
        header_d = src_header_i[5];
        sub_d    = src_sub_i[5];
      end
      default: begin
        header_d = '0;
        sub_d    = '0;
      end
    endcase
  end

  // ACR pending: a new edge wins over a same-cycle grant.
  // Burst counter saturates on audio and clears on every other grant.
  always_comb begin
    acr_pending_d = acr_edge | (acr_pending_q & ~grant_acr);
    burst_d       = burst_q;
    if (packet_enable_i) begin
      if (grant_audio) begin
        if (burst_q != BURST_MAX) begin
          burst_d = burst_q + 1'b1;
        end
      end else begin
        burst_d = '0;
      end
    end
    pop_d = grant_audio;
  end

  // Reset reloads the wrap copy from the live input so no ACR is invented
  always_ff @(posedge clk_pixel_i) begin
    if (reset_i) begin
      wrap_q        <= clk_audio_counter_wrap_i;
      acr_pending_q <= 1'b0;
      burst_q       <= '0;
      packet_src_q  <= PKT_NULL;
      header_q      <= '0;
      sub_q         <= '0;
      pop_q         <= 1'b0;
    end else begin
      wrap_q        <= clk_audio_counter_wrap_i;
      acr_pending_q <= acr_pending_d;
      burst_q       <= burst_d;
      pop_q         <= pop_d;
      if (packet_enable_i) begin
        packet_src_q <= packet_src_d;
        header_q     <= header_d;
        sub_q        <= sub_d;
      end
    end
  end

  assign packet_src_o       = packet_src_q;
  assign header_o           = header_q;
  assign sub_o              = sub_q;
  assign audio_sample_pop_o = pop_q;

endmodule

// File: tb/tb_data_island_scheduler.sv
// tb_data_island_scheduler
// Directed self-checking bench for data_island_scheduler. Two instances share
// all stimulus: dutA with SPD enabled, dutB with SPD disabled. Each packet
// slot checks source, header, subpackets and pop on the cycle after the
// decision, then checks that pop has dropped on the following cycle.
module tb_data_island_scheduler;
  import hdmi_packet_pkg::*;

  logic clkPixel = 1'b0;
  logic reset;
  logic packetEnable;
  logic frameStart;
  logic wrap;
  logic audioReady;
  logic [NUM_SRC:1][HEADER_W-1:0]           srcHeader;
  logic [NUM_SRC:1][NUM_SUB-1:0][SUB_W-1:0] srcSub;

  logic                          popA, popB;
  logic [HEADER_W-1:0]           headerA, headerB;
  logic [NUM_SUB-1:0][SUB_W-1:0] subA, subB;
  pkt_src_t                      srcA, srcB;

  int compared   = 0;
  int mismatched = 0;

  always #5 clkPixel = ~clkPixel;

  data_island_scheduler #(.MAX_AUDIO_BURST(3), .SPD_ENABLE(1'b1)) dutA (
    .clk_pixel_i              (clkPixel),
    .reset_i                  (reset),
    .packet_enable_i          (packetEnable),
    .frame_start_i            (frameStart),
    .clk_audio_counter_wrap_i (wrap),
    .audio_sample_ready_i     (audioReady),
    .src_header_i             (srcHeader),
    .src_sub_i                (srcSub),
    .audio_sample_pop_o       (popA),
    .header_o                 (headerA),
    .sub_o                    (subA),
    .packet_src_o             (srcA)
  );

  data_island_scheduler #(.MAX_AUDIO_BURST(3), .SPD_ENABLE(1'b0)) dutB (
    .clk_pixel_i              (clkPixel),
    .reset_i                  (reset),
    .packet_enable_i          (packetEnable),
    .frame_start_i            (frameStart),
    .clk_audio_counter_wrap_i (wrap),
    .audio_sample_ready_i     (audioReady),
    .src_header_i             (srcHeader),
    .src_sub_i                (srcSub),
    .audio_sample_pop_o       (popB),
    .header_o                 (headerB),
    .sub_o                    (subB),
    .packet_src_o             (srcB)
  );

  // Expected header for a source, built from the same recipe as srcHeader
  function automatic logic [HEADER_W-1:0] expHeader(input pkt_src_t s);
    logic [HEADER_W-1:0] r;
    r = '0;
    if (s != PKT_NULL) r = {8'(int'(s)), 16'hC0DE};
    return r;
  endfunction

  function automatic logic [NUM_SUB*SUB_W-1:0] expSub(input pkt_src_t s);
    logic [NUM_SUB*SUB_W-1:0] r;
    r = '0;
    if (s != PKT_NULL) begin
      for (int j = 0; j < NUM_SUB; j++) begin
        r[j*SUB_W +: SUB_W] = {8'(int'(s)), 8'(j), 40'h5A5A5A5A5A};
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse frame_start and/or toggle the wrap input on an idle cycle
  task automatic applyStimulus(input logic doFrame, input logic doWrap);
    @(negedge clkPixel);
    if (doFrame) frameStart = 1'b1;
    if (doWrap) wrap = ~wrap;
    @(negedge clkPixel);
    frameStart = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clkPixel);
    reset = 1'b1;
    @(negedge clkPixel);
    reset = 1'b0;
    checkOutput("rst.src", 256'(srcA), 256'(PKT_NULL));
    checkOutput("rst.hdr", 256'(headerA), 256'd0);
    checkOutput("rst.sub", 256'(subA), 256'd0);
    checkOutput("rst.pop", 256'(popA), 256'd0);
  endtask

  // One packet slot, optionally with a coincident frame start / wrap edge
  task automatic runSlot(input string tag, input pkt_src_t expA, input pkt_src_t expB,
                         input logic checkB, input logic withFrame, input logic withWrap);
    @(negedge clkPixel);
    packetEnable = 1'b1;
    if (withFrame) frameStart = 1'b1;
    if (withWrap) wrap = ~wrap;
    @(negedge clkPixel);
    packetEnable = 1'b0;
    frameStart   = 1'b0;
    checkOutput({tag, ".src"}, 256'(srcA), 256'(expA));
    checkOutput({tag, ".hdr"}, 256'(headerA), 256'(expHeader(expA)));
    checkOutput({tag, ".sub"}, 256'(subA), 256'(expSub(expA)));
    checkOutput({tag, ".pop"}, 256'(popA), 256'(expA == PKT_AUDIO));
    if (checkB) begin
      checkOutput({tag, ".srcB"}, 256'(srcB), 256'(expB));
      checkOutput({tag, ".hdrB"}, 256'(headerB), 256'(expHeader(expB)));
    end
    @(negedge clkPixel);
    checkOutput({tag, ".popEnd"}, 256'(popA), 256'd0);
    checkOutput({tag, ".hold"}, 256'(srcA), 256'(expA));
  endtask

  pkt_src_t burstSeq [12] = '{PKT_AUDIO, PKT_AUDIO, PKT_AUDIO, PKT_AVI,
                              PKT_AUDIO, PKT_AUDIO, PKT_AUDIO, PKT_AUDIO_INFO,
                              PKT_AUDIO, PKT_AUDIO, PKT_AUDIO, PKT_SPD};
  pkt_src_t dblA [5] = '{PKT_AVI, PKT_AUDIO_INFO, PKT_SPD, PKT_NULL, PKT_NULL};
  pkt_src_t dblB [5] = '{PKT_AVI, PKT_AUDIO_INFO, PKT_NULL, PKT_NULL, PKT_NULL};

  initial begin
    reset        = 1'b1;
    packetEnable = 1'b0;
    frameStart   = 1'b0;
    wrap         = 1'b0;
    audioReady   = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      srcHeader[k] = {8'(k), 16'hC0DE};
      for (int j = 0; j < NUM_SUB; j++) begin
        srcSub[k][j] = {8'(k), 8'(j), 40'h5A5A5A5A5A};
      end
    end

    $display("[TB] reset and idle slots");
    doReset();
    for (int i = 0; i < 4; i++) runSlot($sformatf("idle%0d", i), PKT_NULL, PKT_NULL, 1'b1, 1'b0, 1'b0);

    $display("[TB] single ACR then audio");
    audioReady = 1'b1;
    applyStimulus(1'b0, 1'b1);
    runSlot("acr1", PKT_ACR, PKT_ACR, 1'b1, 1'b0, 1'b0);
    runSlot("aud1", PKT_AUDIO, PKT_AUDIO, 1'b1, 1'b0, 1'b0);
    audioReady = 1'b0;

    $display("[TB] audio burst throttling");
    doReset();
    audioReady = 1'b1;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) runSlot($sformatf("burst%0d", i), burstSeq[i], PKT_NULL, 1'b0, 1'b0, 1'b0);
    audioReady = 1'b0;

    $display("[TB] wrap edge coincident with ACR grant");
    doReset();
    applyStimulus(1'b0, 1'b1);
    runSlot("acrA", PKT_ACR, PKT_ACR, 1'b1, 1'b0, 1'b1);
    runSlot("acrB", PKT_ACR, PKT_ACR, 1'b1, 1'b0, 1'b0);
    runSlot("acrC", PKT_NULL, PKT_NULL, 1'b1, 1'b0, 1'b0);

    $display("[TB] double frame start");
    doReset();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) runSlot($sformatf("dbl%0d", i), dblA[i], dblB[i], 1'b1, 1'b0, 1'b0);

    $display("[TB] frame start coincident with AVI grant");
    doReset();
    applyStimulus(1'b1, 1'b0);
    runSlot("fsg0", PKT_AVI, PKT_AVI, 1'b1, 1'b1, 1'b0);
    runSlot("fsg1", PKT_AVI, PKT_AVI, 1'b1, 1'b0, 1'b0);
    runSlot("fsg2", PKT_AUDIO_INFO, PKT_AUDIO_INFO, 1'b1, 1'b0, 1'b0);
    runSlot("fsg3", PKT_SPD, PKT_NULL, 1'b1, 1'b0, 1'b0);
    runSlot("fsg4", PKT_NULL, PKT_NULL, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset with ACR and AVI pending");
    doReset();
    applyStimulus(1'b1, 1'b1);
    runSlot("pre", PKT_ACR, PKT_ACR, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    doReset();
    for (int i = 0; i < 3; i++) runSlot($sformatf("post%0d", i), PKT_NULL, PKT_NULL, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
